// File: rtl/axi_mem_arbiter_if.sv
// Simplified AXI-style memory bus: AR/R read channels plus AW/W/B write channels.
// Handshake rule for every channel: a transfer happens on the rising clock edge
// where both valid and ready are high. A source holding valid must keep valid and
// its payload stable until that edge; ready may change freely.
interface axi_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              arvalid;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arsize;
    logic              load_unsign;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic              rresp;
    logic              rvalid;
    logic              rready;
    logic              awvalid;
    logic [ADDR_W-1:0] awaddr;
    logic              awready;
    logic              wvalid;
    logic [DATA_W-1:0] wdata;
    logic [31:0]       wstrb;
    logic              wready;
    logic              bresp;
    logic              bvalid;
    logic              bready;

    // Requesting side (a CPU unit, or the arbiter facing the memory)
    modport master (
        output arvalid, araddr, arsize, load_unsign, rready,
        output awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    // Responding side (the memory, or the arbiter facing a CPU unit)
    modport slave (
        input  arvalid, araddr, arsize, load_unsign, rready,
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_mem_arbiter.sv
// Two-master, one-slave memory arbiter. Master 0 (IFU) reads only, master 1 (LSU)
// reads and writes. One whole transaction is granted at a time; writes win, and
// contested reads alternate using last_rd. Routing is purely combinational.
module axi_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi_mem_arbiter_if.slave     m0,
    axi_mem_arbiter_if.slave     m1,
    axi_mem_arbiter_if.master    s,
    output logic [1:0]           state_o,
    output logic                 last_rd_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        WR1  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   last_rd_q, last_rd_d;

    // The IFU never writes; its write-channel inputs are intentionally ignored.
    logic unused_m0_wr;
    assign unused_m0_wr = &{1'b0, m0.awvalid, m0.awaddr, m0.wvalid,
                            m0.wdata, m0.wstrb, m0.bready};

    assign state_o   = state_q;
    assign last_rd_o = last_rd_q;

    // Next-state: arbitrate only in IDLE, release on the granted response handshake.
    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        case (state_q)
            IDLE: begin
                if (m1.awvalid || m1.wvalid) begin
                    state_d = WR1;
                end else if (m0.arvalid && m1.arvalid) begin
                    if (last_rd_q) begin
                        state_d   = RD0;
                        last_rd_d = 1'b0;
                    end else begin
                        state_d   = RD1;
                        last_rd_d = 1'b1;
                    end
                end else if (m0.arvalid) begin
                    state_d   = RD0;
                    last_rd_d = 1'b0;
                end else if (m1.arvalid) begin
                    state_d   = RD1;
                    last_rd_d = 1'b1;
                end
            end
            RD0: if (s.rvalid && m0.rready) state_d = IDLE;
            RD1: if (s.rvalid && m1.rready) state_d = IDLE;
            WR1: if (s.bvalid && m1.bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset makes the first contested read go to the IFU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_rd_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
        end
    end

    // Channel routing: only the granted master's channels are connected, all else 0.
    always_comb begin
        s.arvalid     = 1'b0;
        s.araddr      = {ADDR_W{1'b0}};
        s.arsize      = 4'd0;
        s.load_unsign = 1'b0;
        s.rready      = 1'b0;
        s.awvalid     = 1'b0;
        s.awaddr      = {ADDR_W{1'b0}};
        s.wvalid      = 1'b0;
        s.wdata       = {DATA_W{1'b0}};
        s.wstrb       = 32'd0;
        s.bready      = 1'b0;
        m0.arready    = 1'b0;
        m0.rdata      = {DATA_W{1'b0}};
        m0.rresp      = 1'b0;
        m0.rvalid     = 1'b0;
        m0.awready    = 1'b0;
        m0.wready     = 1'b0;
        m0.bresp      = 1'b0;
        m0.bvalid     = 1'b0;
        m1.arready    = 1'b0;
        m1.rdata      = {DATA_W{1'b0}};
        m1.rresp      = 1'b0;
        m1.rvalid     = 1'b0;
        m1.awready    = 1'b0;
        m1.wready     = 1'b0;
        m1.bresp      = 1'b0;
        m1.bvalid     = 1'b0;
        case (state_q)
            RD0: begin
                s.arvalid     = m0.arvalid;
                s.araddr      = m0.araddr;
                s.arsize      = m0.arsize;
                s.load_unsign = m0.load_unsign;
                s.rready      = m0.rready;
                m0.arready    = s.arready;
                m0.rdata      = s.rdata;
                m0.rresp      = s.rresp;
                m0.rvalid     = s.rvalid;
            end
            RD1: begin
                s.arvalid     = m1.arvalid;
                s.araddr      = m1.araddr;
                s.arsize      = m1.arsize;
                s.load_unsign = m1.load_unsign;
                s.rready      = m1.rready;
                m1.arready    = s.arready;
                m1.rdata      = s.rdata;
                m1.rresp      = s.rresp;
                m1.rvalid     = s.rvalid;
            end
            WR1: begin
                s.awvalid  = m1.awvalid;
                s.awaddr   = m1.awaddr;
                s.wvalid   = m1.wvalid;
                s.wdata    = m1.wdata;
                s.wstrb    = m1.wstrb;
                s.bready   = m1.bready;
                m1.awready = s.awready;
                m1.wready  = s.wready;
                m1.bresp   = s.bresp;
                m1.bvalid  = s.bvalid;
            end
            default: ;
        endcase
    end
endmodule
